// File: rtl/spi_host_master.sv
// -----------------------------------------------------------------------------
// spi_host_master
// SysClk-domain SPI master (mode 0). Turns one accepted host command into a
// single SS-framed SPI packet: a command byte followed by N data bytes.
//   REG_WR   : cmd 0xC0|id, 4 data bytes from cmdWData (MSB byte first)
//   REG_RD   : cmd 0x80|id, 4 zero bytes out, 32 received bits -> rspData
//   BUF_SEND : cmd 0x01, cmdLen bytes taken from the tx byte stream
//   BUF_RECV : cmd 0x03, cmdLen zero bytes out, received bytes -> rx stream
//
// Ports
//   SysClk, Reset            clock, synchronous active-high reset
//   cmdValid/cmdReady        command handshake (ready only while idle)
//   cmdOp/cmdRegId/cmdWData/cmdLen   command fields, latched at accept
//   txByte/txByteValid/txByteReady   outgoing stream (ready = 1-cycle take)
//   rxByte/rxByteValid       incoming stream, no backpressure
//   rspData/rspValid         register read result
//   busy                     high whenever not idle
//   SPI_CLK/SPI_MOSI/SPI_SS  registered SPI outputs; SPI_MISO input
// -----------------------------------------------------------------------------
module spi_host_master #(
  parameter int unsigned ClkDiv  = 8,
  parameter int unsigned LenBits = 12
) (
  input  logic               SysClk,
  input  logic               Reset,
  input  logic               cmdValid,
  output logic               cmdReady,
  input  logic [1:0]         cmdOp,
  input  logic [5:0]         cmdRegId,
  input  logic [31:0]        cmdWData,
  input  logic [LenBits-1:0] cmdLen,
  input  logic [7:0]         txByte,
  input  logic               txByteValid,
  output logic               txByteReady,
  output logic [7:0]         rxByte,
  output logic               rxByteValid,
  output logic [31:0]        rspData,
  output logic               rspValid,
  output logic               busy,
  output logic               SPI_CLK,
  output logic               SPI_MOSI,
  input  logic               SPI_MISO,
  output logic               SPI_SS
);

  localparam logic [1:0] OP_REG_WR   = 2'd0;
  localparam logic [1:0] OP_REG_RD   = 2'd1;
  localparam logic [1:0] OP_BUF_SEND = 2'd2;
  localparam logic [1:0] OP_BUF_RECV = 2'd3;
  localparam logic [7:0] DIV_LAST    = 8'(ClkDiv - 1);

  typedef logic [LenBits:0] cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SS_SETUP = 3'd1,
    ST_LOAD     = 3'd2,
    ST_SHIFT_LO = 3'd3,
    ST_SHIFT_HI = 3'd4,
    ST_SS_HOLD  = 3'd5,
    ST_GAP      = 3'd6
  } state_t;

  function automatic logic [7:0] cmd_byte(input logic [1:0] op, input logic [5:0] id);
    case (op)
      OP_REG_WR:   cmd_byte = {2'b11, id};
      OP_REG_RD:   cmd_byte = {2'b10, id};
      OP_BUF_SEND: cmd_byte = 8'h01;
      OP_BUF_RECV: cmd_byte = 8'h03;
      default:     cmd_byte = 8'h00;
    endcase
  endfunction

  state_t      state_r, state_s;
  logic [1:0]  op_r;
  logic [5:0]  id_r;
  logic [31:0] wdata_r;
  cnt_t        n_data_r;
  cnt_t        byte_cnt_r;
  logic [2:0]  bit_cnt_r;
  logic [7:0]  div_cnt_r;
  logic        gap_half_r;
  logic [7:0]  tx_sh_r;
  logic [31:0] rx_sh_r;
  logic        miso_r;
  logic        rx_pend_r;

  logic        accept_s, div_done_s, last_bit_s, last_byte_s, tx_wait_s;
  logic        byte_end_s, load_s, tx_take_s, div_restart_s, rsp_fire_s;
  logic [7:0]  load_byte_s;
  logic        ss_s, clk_s, mosi_s, cmd_ready_s, busy_s, tx_ready_s;
  logic        rx_valid_s, rsp_valid_s;
  logic [7:0]  rx_byte_s;
  logic [31:0] rsp_data_s;

  assign accept_s    = cmdValid && (state_r == ST_IDLE);
  assign div_done_s  = (div_cnt_r == DIV_LAST);
  assign last_bit_s  = (bit_cnt_r == 3'd7);
  assign last_byte_s = (byte_cnt_r == n_data_r);
  // Only a BUF_SEND data byte can be held up by the upstream stream.
  assign tx_wait_s   = (op_r == OP_BUF_SEND) && !txByteValid;
  assign byte_end_s  = (state_r == ST_SHIFT_HI) && div_done_s && last_bit_s;
  assign rsp_fire_s  = (state_r == ST_SS_HOLD) && div_done_s && (op_r == OP_REG_RD);

  // Byte loads happen on the edge that opens the first low phase, so a load
  // without a stall costs no cycle; a stalled load parks in ST_LOAD.
  assign load_s = ((state_r == ST_SS_SETUP) && div_done_s) ||
                  (byte_end_s && !last_byte_s && !tx_wait_s) ||
                  ((state_r == ST_LOAD) && txByteValid);
  assign tx_take_s = load_s && (state_r != ST_SS_SETUP) && (op_r == OP_BUF_SEND);

  // Byte selected for the next load: command byte first, then data source.
  always_comb begin
    load_byte_s = 8'h00;
    if (state_r == ST_SS_SETUP) begin
      load_byte_s = cmd_byte(op_r, id_r);
    end else begin
      case (op_r)
        OP_REG_WR:   load_byte_s = wdata_r[31:24];
        OP_BUF_SEND: load_byte_s = txByte;
        default:     load_byte_s = 8'h00;
      endcase
    end
  end

  // Divider restarts on every phase boundary and stays parked when untimed.
  assign div_restart_s = div_done_s || (state_s != state_r) ||
                         (state_r == ST_IDLE) || (state_r == ST_LOAD);

  // State register.
  always_ff @(posedge SysClk) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmdValid) state_s = ST_SS_SETUP;
        else          state_s = ST_IDLE;
      end
      ST_SS_SETUP: begin
        if (div_done_s) state_s = ST_SHIFT_LO;
        else            state_s = ST_SS_SETUP;
      end
      ST_LOAD: begin
        if (txByteValid) state_s = ST_SHIFT_LO;
        else             state_s = ST_LOAD;
      end
      ST_SHIFT_LO: begin
        if (div_done_s) state_s = ST_SHIFT_HI;
        else            state_s = ST_SHIFT_LO;
      end
      ST_SHIFT_HI: begin
        if (!div_done_s)      state_s = ST_SHIFT_HI;
        else if (!last_bit_s) state_s = ST_SHIFT_LO;
        else if (last_byte_s) state_s = ST_SS_HOLD;
        else if (tx_wait_s)   state_s = ST_LOAD;
        else                  state_s = ST_SHIFT_LO;
      end
      ST_SS_HOLD: begin
        if (div_done_s) state_s = ST_GAP;
        else            state_s = ST_SS_HOLD;
      end
      ST_GAP: begin
        // The gap is two divider periods; gap_half_r marks the second one.
        if (div_done_s && gap_half_r) state_s = ST_IDLE;
        else                          state_s = ST_GAP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Datapath: command capture, counters, shift registers, MISO stage.
  always_ff @(posedge SysClk) begin
    if (Reset) begin
      op_r       <= 2'd0;
      id_r       <= 6'd0;
      wdata_r    <= 32'd0;
      n_data_r   <= '0;
      byte_cnt_r <= '0;
      bit_cnt_r  <= 3'd0;
      div_cnt_r  <= 8'd0;
      gap_half_r <= 1'b0;
      tx_sh_r    <= 8'd0;
      rx_sh_r    <= 32'd0;
      miso_r     <= 1'b0;
      rx_pend_r  <= 1'b0;
    end else begin
      miso_r     <= SPI_MISO;
      div_cnt_r  <= div_restart_s ? 8'd0 : div_cnt_r + 8'd1;
      gap_half_r <= (state_r == ST_GAP) ? (gap_half_r ^ div_done_s) : 1'b0;
      rx_pend_r  <= (state_r == ST_SHIFT_LO) && div_done_s && last_bit_s &&
                    (byte_cnt_r != '0) && (op_r == OP_BUF_RECV);

      if (accept_s) begin
        op_r       <= cmdOp;
        id_r       <= cmdRegId;
        wdata_r    <= cmdWData;
        n_data_r   <= cmdOp[1] ? {1'b0, cmdLen} : cnt_t'(3'd4);
        byte_cnt_r <= '0;
        bit_cnt_r  <= 3'd0;
      end else if (load_s) begin
        tx_sh_r   <= load_byte_s;
        bit_cnt_r <= 3'd0;
        if ((state_r != ST_SS_SETUP) && (op_r == OP_REG_WR)) begin
          wdata_r <= {wdata_r[23:0], 8'h00};
        end else begin
          wdata_r <= wdata_r;
        end
      end else if ((state_r == ST_SHIFT_HI) && div_done_s && !last_bit_s) begin
        tx_sh_r   <= {tx_sh_r[6:0], 1'b0};
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end

      if (byte_end_s) begin
        byte_cnt_r <= byte_cnt_r + cnt_t'(1'b1);
      end else if (accept_s) begin
        byte_cnt_r <= '0;
      end else begin
        byte_cnt_r <= byte_cnt_r;
      end

      // Sample on the edge that raises SPI_CLK.
      if ((state_r == ST_SHIFT_LO) && div_done_s) begin
        rx_sh_r <= {rx_sh_r[30:0], miso_r};
      end else begin
        rx_sh_r <= rx_sh_r;
      end
    end
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    ss_s        = (state_s == ST_IDLE) || (state_s == ST_GAP);
    clk_s       = (state_s == ST_SHIFT_HI);
    cmd_ready_s = (state_s == ST_IDLE);
    busy_s      = (state_s != ST_IDLE);
    tx_ready_s  = tx_take_s;
    rsp_valid_s = rsp_fire_s;
    rsp_data_s  = rsp_fire_s ? rx_sh_r : rspData;
    rx_valid_s  = rx_pend_r;
    rx_byte_s   = rx_pend_r ? rx_sh_r[7:0] : rxByte;
    if (load_s) begin
      mosi_s = load_byte_s[7];
    end else if ((state_r == ST_SHIFT_HI) && div_done_s && !last_bit_s) begin
      mosi_s = tx_sh_r[6];
    end else if (ss_s || (state_s == ST_SS_HOLD)) begin
      mosi_s = 1'b0;
    end else begin
      mosi_s = SPI_MOSI;
    end
  end

  // Output registers.
  always_ff @(posedge SysClk) begin
    if (Reset) begin
      SPI_SS      <= 1'b1;
      SPI_CLK     <= 1'b0;
      SPI_MOSI    <= 1'b0;
      cmdReady    <= 1'b1;
      busy        <= 1'b0;
      txByteReady <= 1'b0;
      rxByteValid <= 1'b0;
      rxByte      <= 8'd0;
      rspValid    <= 1'b0;
      rspData     <= 32'd0;
    end else begin
      SPI_SS      <= ss_s;
      SPI_CLK     <= clk_s;
      SPI_MOSI    <= mosi_s;
      cmdReady    <= cmd_ready_s;
      busy        <= busy_s;
      txByteReady <= tx_ready_s;
      rxByteValid <= rx_valid_s;
      rxByte      <= rx_byte_s;
      rspValid    <= rsp_valid_s;
      rspData     <= rsp_data_s;
    end
  end

endmodule

// File: doc/spi_host_master.md
Name: spi_host_master

Overview:
- SysClk-domain SPI master that drives the command-based SPI slave interface: SPI_CLK, SPI_MOSI and SPI_SS out, SPI_MISO in.
- Sits directly upstream of the slave, as the on-chip host or loopback stage for bring-up and regression.
- Turns one accepted host command into exactly one SS-framed SPI packet: register write, register read, buffer send or buffer receive.
- Carries byte streams over valid/ready handshakes.

Parameters:
- ClkDiv, 8: SPI half-period in SysClk cycles. Legal range 4..255; the slave needs 4 or more for its input synchronisers.
- LenBits, 12: width of the buffer-op byte count.

Ports:
- SysClk  in  1  system clock.
- Reset  in  1  reset, synchronous, active-high.
- cmdValid  in  1  command request.
- cmdReady  out  1  high only in IDLE; accept = cmdValid && cmdReady.
- cmdOp  in  2  operation: 0 REG_WR, 1 REG_RD, 2 BUF_SEND, 3 BUF_RECV.
- cmdRegId  in  6  register id (reg ops).
- cmdWData  in  32  register write data (REG_WR).
- cmdLen  in  LenBits  data-byte count (buffer ops); 0 is legal.
- txByte  in  8  outgoing stream byte (BUF_SEND).
- txByteValid  in  1  txByte available.
- txByteReady  out  1  one-cycle pulse; consumes txByte.
- rxByte  out  8  received stream byte (BUF_RECV).
- rxByteValid  out  1  one-cycle pulse; no backpressure.
- rspData  out  32  REG_RD result.
- rspValid  out  1  one-cycle pulse when rspData updates.
- busy  out  1  high when not in IDLE.
- SPI_CLK  out  1  SPI clock, mode 0, idle low.
- SPI_MOSI  out  1  master data out, MSB first.
- SPI_MISO  in  1  slave data in; registered once before use.
- SPI_SS  out  1  active-low slave select.

Behaviour:
- All SPI outputs are registered.

Reset (all values forced on the cycle Reset is sampled high, including mid-packet):
- SPI_SS=1, SPI_CLK=0, SPI_MOSI=0.
- state=IDLE; cmdReady=1; busy=0.
- rspValid=0, rxByteValid=0, txByteReady=0; rspData=0, rxByte=0.
- All counters 0; the in-flight command is discarded.

Command capture at accept (cycle E0): latch op, id, wdata and len.

Packet contents:
- Command byte:
  - REG_WR = 0xC0|id
  - REG_RD = 0x80|id
  - BUF_SEND = 0x01
  - BUF_RECV = 0x03
- Data bytes N:
  - REG_WR: N=4, cmdWData MSB byte first.
  - REG_RD: N=4, MOSI=0.
  - BUF_SEND: N=cmdLen, bytes from the tx stream.
  - BUF_RECV: N=cmdLen, MOSI=0.

FSM:
- IDLE -> SS_SETUP on accept.
- SS_SETUP: SPI_SS=0 from E0+1, held ClkDiv cycles.
- LOAD: selects the next byte into an 8-bit shift register.
  - BUF_SEND data byte: waits while txByteValid=0. SPI_CLK stays low and SPI_SS stays low during the stall. txByteReady pulses on the load cycle.
  - Load consumes no extra cycle when no wait is needed; it merges into the first low-phase cycle.
- SHIFT, per bit:
  - Low phase: ClkDiv cycles; MOSI updated on its first cycle.
  - High phase: ClkDiv cycles.
  - On the cycle SPI_CLK goes high, the registered MISO is shifted into the receive register.
  - After 8 bits: if more bytes remain, go to LOAD; otherwise go to SS_HOLD.
- SS_HOLD: SPI_CLK=0 and SPI_SS=0 for ClkDiv cycles.
- GAP: SPI_SS=1 for 2*ClkDiv cycles, then IDLE.

Timing with no stalls:
- SPI_SS rises at E0+1+ClkDiv+16*ClkDiv*(N+1)+ClkDiv.
- cmdReady returns 2*ClkDiv cycles after SPI_SS rises.

Response and stream outputs:
- REG_RD: bytes 1..4 received, MSB first, are assembled into rspData. rspData and the rspValid pulse occur on the SPI_SS rising cycle.
- Command-byte MISO is never reported.
- BUF_RECV: rxByte updates and rxByteValid pulses 1 cycle after the 8th sample of each data byte.
- cmdLen=0: only the command byte is sent; no stream activity.
- Inputs cmdValid and txByteValid outside their use windows are ignored; txByteReady never pulses outside BUF_SEND.
- Counters: bit 3b; byte LenBits+1 b; divider 8b. No wrap: cmdLen max 2^LenBits-1 is transferred exactly.

Test Plan:
- Reset, then REG_WR id=5 wdata=0xDEADBEEF, ClkDiv=8:
  - MOSI bytes 0xC5,DE,AD,BE,EF.
  - SS low E0+1..E0+656; cmdReady high at E0+673.
  - Slave regWriteEn pulses once with 0xDEADBEEF.
- REG_RD id=2 with slave regReadData=0x12345678:
  - MOSI 0x82 then zeros.
  - rspValid single pulse, rspData=0x12345678.
- BUF_SEND len=3, bytes 0xA1,0xB2,0xC3, with txByteValid dropped for 50 cycles before byte 2:
  - SPI_CLK low and SS low throughout the stall.
  - Slave rcMem addresses 0..2 = A1,B2,C3.
  - Exactly 3 txByteReady pulses.
- BUF_RECV len=4 with slave txMem = 0x10,20,30,40:
  - 4 rxByteValid pulses with those values in order.
  - First MOSI byte 0x03.
- Reset asserted mid-REG_WR during bit 20:
  - Next cycle SS=1, SPI_CLK=0, cmdReady=1.
  - A following REG_RD completes correctly.
- cmdLen=0 BUF_SEND:
  - 8 SPI_CLK rises only, no txByteReady.
  - cmdReady back 4*ClkDiv+16*ClkDiv+1 cycles after accept.
